// File: rtl/fwd_ctrl.sv
// fwd_ctrl: operand forwarding and load-use hazard control for a 5-stage pipeline.
// It tracks the instructions sitting in EX, MEM and WB, selects the EX operand
// sources, and requests a one-cycle stall when a load feeds the instruction behind it.
//
// Control semantics (one rule set, no handshake ports):
//   - stall is combinational and is asserted in the cycle the dependent
//     instruction sits in decode; the front end holds PC and IF/ID for that cycle.
//   - flush squashes whatever would enter EX this edge, and it wins over stall.
//   - EX receives a bubble whenever stall, flush, or !id_valid.
//   - stall_cnt counts edges where stall=1 and flush=0, saturating at 16'hFFFF.
module fwd_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } ex_rec_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } mem_rec_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       regwrite;
  } wb_rec_t;

  ex_rec_t  ex_q,  ex_d;
  mem_rec_t mem_q, mem_d;
  wb_rec_t  wb_q,  wb_d;

  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  logic stall_hit;
  logic stall_count_en;
  logic issue_en;
  logic mem_can_fwd;
  logic wb_can_fwd;

  // Load-use hazard: the load in EX has not produced data yet, so a consumer in
  // decode must wait one cycle. Register 0 is hardwired and never a hazard.
  always_comb begin
    stall_hit = 1'b0;
    if (id_valid && ex_q.valid && ex_q.memread && (ex_q.dst != 5'd0) &&
        ((ex_q.dst == id_rs) || (ex_q.dst == id_rt))) begin
      stall_hit = 1'b1;
    end
  end

  assign stall          = stall_hit;
  assign stall_count_en = stall_hit & ~flush;
  assign issue_en       = id_valid & ~stall_hit & ~flush;

  // Operand source selection. A load in MEM has no ALU result to forward, so it
  // is skipped there and only becomes a source once its data reaches WB.
  always_comb begin
    mem_can_fwd = mem_q.valid & mem_q.regwrite & ~mem_q.memread & (mem_q.dst != 5'd0);
    wb_can_fwd  = wb_q.valid & wb_q.regwrite & (wb_q.dst != 5'd0);
    fwd_a = SEL_RF;
    fwd_b = SEL_RF;
    if (ex_q.valid) begin
      if (mem_can_fwd && (mem_q.dst == ex_q.rs)) begin
        fwd_a = SEL_MEM;
      end else if (wb_can_fwd && (wb_q.dst == ex_q.rs)) begin
        fwd_a = SEL_WB;
      end
      if (mem_can_fwd && (mem_q.dst == ex_q.rt)) begin
        fwd_b = SEL_MEM;
      end else if (wb_can_fwd && (wb_q.dst == ex_q.rt)) begin
        fwd_b = SEL_WB;
      end
    end
  end

  // Next-state of the stage records: shift down, inject a bubble into EX when
  // nothing legitimate is issuing.
  always_comb begin
    ex_d           = '0;
    mem_d          = '0;
    wb_d           = '0;
    if (issue_en) begin
      ex_d.valid    = 1'b1;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.dst      = id_dst;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
    mem_d.valid    = ex_q.valid;
    mem_d.dst      = ex_q.dst;
    mem_d.regwrite = ex_q.regwrite;
    mem_d.memread  = ex_q.memread;
    wb_d.valid     = mem_q.valid;
    wb_d.dst       = mem_q.dst;
    wb_d.regwrite  = mem_q.regwrite;
  end

  // Saturating stall counter next value; kept as a plain net so it is easy to observe.
  assign stall_cnt_d = (stall_count_en && (stall_cnt_q != 16'hFFFF)) ?
                       (stall_cnt_q + 16'd1) : stall_cnt_q;

  // Stage records and counter; reset discards every in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
